// File: rtl/exmem_pipeline_pkg.sv
// rtl/exmem_pipeline_pkg.sv - shared widths and FSM encoding for the EX/MEM pipeline register
package exmem_pipeline_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/exmem_pipeline_if.sv
// rtl/exmem_pipeline_if.sv - EX/MEM stage bundle: execute-side inputs, memory-side outputs
interface exmem_pipeline_if
  import exmem_pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);

  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [DATA_W-1:0] Instr_ToM;
  logic [DATA_W-1:0] PCInc_ToM;
  logic [DATA_W-1:0] ALURes_ToM;
  logic [DATA_W-1:0] RD2_ToM;
  logic [REG_W-1:0]  WriteReg_ToM;
  logic              MemReadEn_ToM;
  logic              MemWriteEn_ToM;
  logic              WriteToReg_ToM;
  logic              RegWriteDataSel_ToM;
  logic              Halt_ToM;

  logic [DATA_W-1:0] Instr_FromX;
  logic [DATA_W-1:0] PCInc_FromX;
  logic [DATA_W-1:0] ALURes_FromX;
  logic [DATA_W-1:0] RD2_FromX;
  logic [REG_W-1:0]  WriteReg_FromX;
  logic              MemReadEn_FromX;
  logic              MemWriteEn_FromX;
  logic              WriteToReg_FromX;
  logic              RegWriteDataSel_FromX;
  logic              Halt_FromX;
  logic              valid_out;
  logic              halted;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  logic              load_use;

  modport slave (
    input  stall, flush, valid_in, Instr_ToM, PCInc_ToM, ALURes_ToM, RD2_ToM, WriteReg_ToM,
           MemReadEn_ToM, MemWriteEn_ToM, WriteToReg_ToM, RegWriteDataSel_ToM, Halt_ToM,
    output Instr_FromX, PCInc_FromX, ALURes_FromX, RD2_FromX, WriteReg_FromX, MemReadEn_FromX,
           MemWriteEn_FromX, WriteToReg_FromX, RegWriteDataSel_FromX, Halt_FromX, valid_out,
           halted, fwd_valid, fwd_reg, fwd_data, load_use
  );

  modport master (
    output stall, flush, valid_in, Instr_ToM, PCInc_ToM, ALURes_ToM, RD2_ToM, WriteReg_ToM,
           MemReadEn_ToM, MemWriteEn_ToM, WriteToReg_ToM, RegWriteDataSel_ToM, Halt_ToM,
    input  Instr_FromX, PCInc_FromX, ALURes_FromX, RD2_FromX, WriteReg_FromX, MemReadEn_FromX,
           MemWriteEn_FromX, WriteToReg_FromX, RegWriteDataSel_FromX, Halt_FromX, valid_out,
           halted, fwd_valid, fwd_reg, fwd_data, load_use
  );

endinterface

// File: rtl/exmem_field_reg.sv
// rtl/exmem_field_reg.sv - width-parameterised pipeline register, priority clear > hold > load
module exmem_field_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         hold_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (!hold_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/exmem_pipeline.sv
// rtl/exmem_pipeline.sv - EX/MEM pipeline register with halt FSM and forwarding/hazard taps
// Optional stall/bubble counters are built when EXMEM_PERF_CNT_EN is defined.
module exmem_pipeline
  import exmem_pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  exmem_pipeline_if.slave   bus
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  localparam int DG_W = 4 * DATA_W;
  localparam int CG_W = REG_W + 6;

  state_e state_q, state_d;
  logic   run;
  logic   clr;
  logic   hold;
  logic   capture;

  logic [DG_W-1:0] data_d, data_q;
  logic [CG_W-1:0] ctrl_d, ctrl_q;

  logic [REG_W-1:0] wreg_q;
  logic mre_q, mwe_q, wtr_q, sel_q, halt_q, valid_q;

  assign run     = (state_q == ST_RUN);
  // Flush outranks stall because the field register gives clear priority over hold.
  assign clr     = run & (bus.flush | (~bus.stall & ~bus.valid_in));
  assign hold    = ~run | bus.stall;
  assign capture = run & ~bus.stall & ~bus.flush & bus.valid_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (capture && bus.Halt_ToM) begin
      state_d = ST_HALTED;
    end
  end

  assign data_d = {bus.Instr_ToM, bus.PCInc_ToM, bus.ALURes_ToM, bus.RD2_ToM};
  assign ctrl_d = {bus.WriteReg_ToM, bus.MemReadEn_ToM, bus.MemWriteEn_ToM, bus.WriteToReg_ToM,
                   bus.RegWriteDataSel_ToM, bus.Halt_ToM, 1'b1};

  exmem_field_reg #(.W(DG_W)) u_data_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (clr),
    .hold_i(hold),
    .d_i   (data_d),
    .q_o   (data_q)
  );

  exmem_field_reg #(.W(CG_W)) u_ctrl_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (clr),
    .hold_i(hold),
    .d_i   (ctrl_d),
    .q_o   (ctrl_q)
  );

  assign {bus.Instr_FromX, bus.PCInc_FromX, bus.ALURes_FromX, bus.RD2_FromX} = data_q;
  assign {wreg_q, mre_q, mwe_q, wtr_q, sel_q, halt_q, valid_q} = ctrl_q;

  assign bus.WriteReg_FromX        = wreg_q;
  assign bus.MemReadEn_FromX       = mre_q;
  // A halted pipe must never keep issuing the store it froze on.
  assign bus.MemWriteEn_FromX      = mwe_q & run;
  assign bus.WriteToReg_FromX      = wtr_q;
  assign bus.RegWriteDataSel_FromX = sel_q;
  assign bus.Halt_FromX            = halt_q;
  assign bus.valid_out             = valid_q;
  assign bus.halted                = (state_q == ST_HALTED);

  assign bus.fwd_valid = valid_q & wtr_q & ~mre_q;
  assign bus.fwd_reg   = wreg_q;
  assign bus.fwd_data  = bus.ALURes_FromX;
  assign bus.load_use  = valid_q & mre_q & wtr_q;

`ifdef EXMEM_PERF_CNT_EN
  logic [15:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (run && bus.stall && !bus.flush && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (clr && bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
